sram_req_arbiter: RTL and testbench
===================================

# sram_req_arbiter

Arbitrates the instruction-fetch and data-access SRAM-like request ports onto one shared SRAM-like memory port, tracking outstanding transactions in order so each response returns to its issuing requester. Sits between the IF/EXE stages (request side) and the memory bridge (slave side). Data requests have priority, with a starvation guard for instruction fetch. Response order on the slave port is strictly in-order.

## Interface
- MAX_OUTST, 4, maximum outstanding accepted-but-unanswered transactions; power of 2, ≥2
- STARVE_LIM, 4, consecutive contested data grants after which the next contested grant goes to inst
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- inst_req / data_req  in  1  request valid
- inst_wr / data_wr  in  1  1 = write
- inst_wen / data_wen  in  4  byte write enables
- inst_addr / data_addr  in  32  physical address
- inst_wdata / data_wdata  in  32  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this requester's oldest transaction
- inst_rdata / data_rdata  out  32  read data, valid with the matching data_ok
- mem_req  out  1  shared-port request valid
- mem_wr, mem_wen[3:0], mem_addr[31:0], mem_wdata[31:0]  out  muxed from the granted requester
- mem_addr_ok  in  1  slave accepted request
- mem_data_ok  in  1  slave response (in order)
- mem_rdata  in  32  slave read data
- outst_cnt  out  log2(MAX_OUTST)+1  current outstanding count
- err_spurious  out  1  sticky: mem_data_ok seen with no outstanding transaction

## Operation
- Order FIFO: MAX_OUTST entries, 1-bit owner (0 = inst, 1 = data); wrptr/rdptr of log2(MAX_OUTST)+1 bits with wrap bit; full when pointers differ only in the MSB, empty when equal.
- Grant (combinational): if only one requester is active, it wins. If both are active, data wins unless starve_cnt == STARVE_LIM, in which case inst wins.
- starve_cnt: increments on each contested cycle accepted for data (saturating at STARVE_LIM); clears to 0 on any inst acceptance; unchanged otherwise.
- mem_req = (inst_req | data_req) & !full. The mem_* payload comes from the grant winner; when mem_req = 0 the payload is don't-care.
- Accept = mem_req & mem_addr_ok. On accept, the winner's addr_ok = 1, the loser's addr_ok = 0, and the owner bit is pushed.
- On mem_data_ok with FIFO non-empty: pop; owner's data_ok = 1; mem_rdata is routed to both rdata outputs. A write response also produces data_ok.
- On mem_data_ok with FIFO empty: no data_ok, no pop; err_spurious set until reset.
- Same-cycle push and pop: both occur and the count is unchanged. Full is evaluated before the pop, so when full no push occurs even if a pop happens in the same cycle.
- A response may pop in the same cycle as a new accept for the same owner. The popped entry is the older one.
- Reset mid-operation: the FIFO empties, starve_cnt = 0, and err_spurious = 0. The slave must be reset in the same cycle; late responses after reset set err_spurious.

## Timing
- Reset values: mem_req = 0, all addr_ok/data_ok = 0, outst_cnt = 0, err_spurious = 0.
- Request path: 0-cycle combinational from *_req to mem_req and payload. addr_ok is combinational from mem_addr_ok.
- Response path: 0-cycle combinational from mem_data_ok/mem_rdata to *_data_ok/*_rdata.
- FIFO pointers, starve_cnt and err_spurious update at the clk edge following the handshake.
- Requesters must hold req and payload until addr_ok. The arbiter may switch the grant between cycles while no accept has occurred.
- Throughput: one accept and one response per cycle.

## Test plan
- Single inst read: addr 0xBFC00000, mem_addr_ok the same cycle, mem_data_ok 3 cycles later with rdata 0x3C1DBFC0 -> inst_addr_ok in cycle 0; inst_data_ok and rdata in cycle 3; data_data_ok stays 0; outst_cnt goes 1 then 0.
- Contention: inst_req and data_req high for 6 cycles, mem_addr_ok = 1, STARVE_LIM = 4 -> data accepted in cycles 0–3, inst in cycle 4, data in cycle 5.
- Ordering: accept data write (wen 0xF), then inst read, then data read; return three mem_data_ok back-to-back -> data_ok, inst_ok, data_ok in that order, with rdata matched to each.
- Full: MAX_OUTST = 4, 4 accepts with no responses -> mem_req = 0 and no addr_ok while requests are held. A mem_data_ok in cycle 5 pops one entry; the next accept occurs in cycle 6.
- Spurious/reset: mem_data_ok while empty -> no data_ok, err_spurious = 1. Assert reset with 2 outstanding -> outst_cnt = 0 and err_spurious = 0 the next cycle.
- Simultaneous push and pop at count 2 -> count stays 2, and the response routes to the older owner.

Source files
------------

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: merges the inst-fetch and data SRAM-like request ports onto
// one shared SRAM-like port and routes in-order responses back to their owner.
module sram_req_arbiter #(
    parameter int unsigned MAX_OUTST  = 4,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                             clk,
    input  logic                             reset,

    input  logic                             inst_req,
    input  logic                             inst_wr,
    input  logic [3:0]                       inst_wen,
    input  logic [31:0]                      inst_addr,
    input  logic [31:0]                      inst_wdata,
    output logic                             inst_addr_ok,
    output logic                             inst_data_ok,
    output logic [31:0]                      inst_rdata,

    input  logic                             data_req,
    input  logic                             data_wr,
    input  logic [3:0]                       data_wen,
    input  logic [31:0]                      data_addr,
    input  logic [31:0]                      data_wdata,
    output logic                             data_addr_ok,
    output logic                             data_data_ok,
    output logic [31:0]                      data_rdata,

    output logic                             mem_req,
    output logic                             mem_wr,
    output logic [3:0]                       mem_wen,
    output logic [31:0]                      mem_addr,
    output logic [31:0]                      mem_wdata,
    input  logic                             mem_addr_ok,
    input  logic                             mem_data_ok,
    input  logic [31:0]                      mem_rdata,

    output logic [$clog2(MAX_OUTST):0]       outst_cnt,
    output logic                             err_spurious
);

    localparam int unsigned PW   = $clog2(MAX_OUTST);
    localparam int unsigned PTRW = PW + 1;
    localparam int unsigned SCW  = $clog2(STARVE_LIM + 1);

    // Owner FIFO (0 = inst, 1 = data), pointers carry a wrap bit.
    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [PTRW-1:0]      wrptr_q, wrptr_d;
    logic [PTRW-1:0]      rdptr_q, rdptr_d;
    logic [SCW-1:0]       starve_q, starve_d;
    logic                 err_q, err_d;

    logic                 full;
    logic                 empty;
    logic                 contested;
    logic                 grant_data;
    logic                 accept;
    logic                 pop;
    logic                 head_owner;

    // FIFO status from the registered pointers (evaluated before any pop).
    always_comb begin
        full  = (wrptr_q[PW] != rdptr_q[PW]) && (wrptr_q[PW-1:0] == rdptr_q[PW-1:0]);
        empty = (wrptr_q == rdptr_q);
    end

    // Grant: data wins contention unless inst has been starved STARVE_LIM times.
    always_comb begin
        contested  = inst_req & data_req;
        grant_data = 1'b0;
        if (data_req && !inst_req) begin
            grant_data = 1'b1;
        end else if (contested) begin
            grant_data = (starve_q != SCW'(STARVE_LIM));
        end
    end

    // Shared-port request and payload mux from the grant winner.
    always_comb begin
        mem_req   = (inst_req | data_req) & ~full;
        mem_wr    = inst_wr;
        mem_wen   = inst_wen;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
        if (grant_data) begin
            mem_wr    = data_wr;
            mem_wen   = data_wen;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
    end

    // Request handshake back to the winner.
    always_comb begin
        accept       = mem_req & mem_addr_ok;
        inst_addr_ok = accept & ~grant_data;
        data_addr_ok = accept &  grant_data;
    end

    // Response routing to the owner of the oldest outstanding transaction.
    always_comb begin
        pop          = mem_data_ok & ~empty;
        head_owner   = owner_q[rdptr_q[PW-1:0]];
        inst_data_ok = pop & ~head_owner;
        data_data_ok = pop &  head_owner;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    // Next-state for FIFO, starvation counter and sticky spurious flag.
    always_comb begin
        owner_d  = owner_q;
        wrptr_d  = wrptr_q;
        rdptr_d  = rdptr_q;
        starve_d = starve_q;
        err_d    = err_q;

        if (accept) begin
            owner_d[wrptr_q[PW-1:0]] = grant_data;
            wrptr_d                  = wrptr_q + PTRW'(1);
            if (!grant_data) begin
                starve_d = '0;
            end else if (contested && (starve_q != SCW'(STARVE_LIM))) begin
                starve_d = starve_q + SCW'(1);
            end
        end

        if (pop) begin
            rdptr_d = rdptr_q + PTRW'(1);
        end

        if (mem_data_ok && empty) begin
            err_d = 1'b1;
        end
    end

    // State registers, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= '0;
            wrptr_q  <= '0;
            rdptr_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            wrptr_q  <= wrptr_d;
            rdptr_q  <= rdptr_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Pointer difference is the occupancy; the wrap bit makes it exact.
    always_comb begin
        outst_cnt    = wrptr_q - rdptr_q;
        err_spurious = err_q;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed cycles checked against an owner-queue
// scoreboard plus explicit expectations for each scenario.
module tb_sram_req_arbiter;

    localparam int unsigned MAXO = 4;
    localparam int unsigned LIM  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [3:0]  inst_wen, data_wen;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  outst_cnt;
    logic        err_spurious;

    sram_req_arbiter #(.MAX_OUTST(MAXO), .STARVE_LIM(LIM)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_wen(inst_wen),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Scoreboard: owner of each accepted transaction (0 = inst, 1 = data).
    bit q_own[$];
    int m_starve = 0;
    bit m_err    = 1'b0;

    // Observed values captured at the last check point.
    logic cap_iaok, cap_daok, cap_idok, cap_ddok, cap_mreq, cap_err;
    logic [31:0] cap_rdata;
    logic [2:0]  cap_cnt;
    logic [5:0]  grants;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check against the model, advance model at the edge.
    task automatic cycle(input logic ir, input logic dr, input logic dw,
                         input logic aok, input logic dok,
                         input logic [31:0] rd, input logic r);
        bit m_full, m_mreq, m_gd, m_acc, m_pop, m_own, was_empty;
        reset       = r;
        inst_req    = ir;
        data_req    = dr;
        data_wr     = dw;
        data_wen    = dw ? 4'hF : 4'h0;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        #3;
        was_empty = (q_own.size() == 0);
        m_full    = (q_own.size() == MAXO);
        m_mreq    = (ir | dr) & !m_full;
        m_gd      = dr & (!ir | (m_starve != LIM));
        m_acc     = m_mreq & aok;
        m_pop     = dok & !was_empty;
        m_own     = m_pop ? q_own[0] : 1'b0;
        cap_iaok  = inst_addr_ok;
        cap_daok  = data_addr_ok;
        cap_idok  = inst_data_ok;
        cap_ddok  = data_data_ok;
        cap_mreq  = mem_req;
        cap_err   = err_spurious;
        cap_cnt   = outst_cnt;
        cap_rdata = inst_rdata;
        if (!r) begin
            check("mem_req",      32'(mem_req),      32'(m_mreq));
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(m_acc & !m_gd));
            check("data_addr_ok", 32'(data_addr_ok), 32'(m_acc & m_gd));
            check("inst_data_ok", 32'(inst_data_ok), 32'(m_pop & !m_own));
            check("data_data_ok", 32'(data_data_ok), 32'(m_pop & m_own));
            check("outst_cnt",    32'(outst_cnt),    32'(q_own.size()));
            check("err_spurious", 32'(err_spurious), 32'(m_err));
            if (m_pop) begin
                check("inst_rdata", inst_rdata, rd);
                check("data_rdata", data_rdata, rd);
            end
            if (m_mreq) begin
                check("mem_addr",  mem_addr,         m_gd ? data_addr : inst_addr);
                check("mem_wr",    32'(mem_wr),      32'(m_gd ? dw : 1'b0));
                check("mem_wen",   32'(mem_wen),     32'(m_gd ? (dw ? 4'hF : 4'h0) : 4'h0));
                check("mem_wdata", mem_wdata,        m_gd ? data_wdata : inst_wdata);
            end
        end
        @(posedge clk);
        if (r) begin
            q_own.delete();
            m_starve = 0;
            m_err    = 1'b0;
        end else begin
            if (m_pop) void'(q_own.pop_front());
            if (m_acc) begin
                q_own.push_back(m_gd);
                if (!m_gd) m_starve = 0;
                else if (ir && dr && m_starve < LIM) m_starve++;
            end
            if (dok && was_empty) m_err = 1'b1;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        inst_wr    = 1'b0;
        inst_wen   = 4'h0;
        inst_addr  = 32'hBFC0_0000;
        inst_wdata = 32'h0;
        data_addr  = 32'h8000_1000;
        data_wdata = 32'hDEAD_BEEF;
        reset = 1'b1; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wen = 4'h0;
        mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        cycle(0, 0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 0, 32'h0, 1);

        // Reset values.
        cycle(0, 0, 0, 1, 0, 32'h0, 0);
        check("rst_mem_req", 32'(cap_mreq), 32'd0);
        check("rst_cnt",     32'(cap_cnt),  32'd0);
        check("rst_err",     32'(cap_err),  32'd0);

        // Single inst read, response three cycles after accept.
        cycle(1, 0, 0, 1, 0, 32'h0, 0);
        check("t1_iaok", 32'(cap_iaok), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t1_cnt1", 32'(cap_cnt), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 1, 32'h3C1D_BFC0, 0);
        check("t1_idok",  32'(cap_idok), 32'd1);
        check("t1_ddok",  32'(cap_ddok), 32'd0);
        check("t1_rdata", cap_rdata,     32'h3C1D_BFC0);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t1_cnt0", 32'(cap_cnt), 32'd0);

        // Contention for six cycles, responses trailing by one to avoid full.
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 1, (i != 0), 32'h1000 + 32'(i), 0);
            grants[i] = cap_daok;
            check("t2_one_grant", 32'(cap_iaok ^ cap_daok), 32'd1);
        end
        check("t2_grant_seq", 32'(grants), 32'b10_1111);
        cycle(0, 0, 0, 0, 1, 32'h1006, 0);
        check("t2_last_ddok", 32'(cap_ddok), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t2_cnt0", 32'(cap_cnt), 32'd0);

        // Ordering: data write, inst read, data read; three responses back to back.
        cycle(0, 1, 1, 1, 0, 32'h0, 0);
        cycle(1, 0, 0, 1, 0, 32'h0, 0);
        cycle(0, 1, 0, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 1, 32'hAAAA_0001, 0);
        check("t3_r0_ddok", 32'(cap_ddok), 32'd1);
        cycle(0, 0, 0, 0, 1, 32'hAAAA_0002, 0);
        check("t3_r1_idok", 32'(cap_idok), 32'd1);
        check("t3_r1_data", cap_rdata, 32'hAAAA_0002);
        cycle(0, 0, 0, 0, 1, 32'hAAAA_0003, 0);
        check("t3_r2_ddok", 32'(cap_ddok), 32'd1);

        // Full: four accepts, then held requests stall until a response frees a slot.
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 1, 0, 32'h0, 0);
        cycle(1, 1, 0, 1, 0, 32'h0, 0);
        check("t4_full_mreq", 32'(cap_mreq), 32'd0);
        check("t4_full_aok",  32'(cap_iaok | cap_daok), 32'd0);
        check("t4_full_cnt",  32'(cap_cnt), 32'd4);
        cycle(1, 1, 0, 1, 1, 32'h5555_0000, 0);
        check("t4_pop_noacc", 32'(cap_iaok | cap_daok), 32'd0);
        cycle(1, 1, 0, 1, 0, 32'h0, 0);
        check("t4_next_acc",  32'(cap_iaok | cap_daok), 32'd1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 32'h5555_0001 + 32'(i), 0);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t4_drained", 32'(cap_cnt), 32'd0);

        // Spurious response while empty, then reset with two outstanding.
        cycle(0, 0, 0, 0, 1, 32'h7777_7777, 0);
        check("t5_no_idok", 32'(cap_idok | cap_ddok), 32'd0);
        cycle(1, 0, 0, 1, 0, 32'h0, 0);
        check("t5_err_set", 32'(cap_err), 32'd1);
        cycle(0, 1, 0, 1, 0, 32'h0, 0);
        cycle(0, 0, 0, 0, 0, 32'h0, 1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t5_rst_cnt", 32'(cap_cnt), 32'd0);
        check("t5_rst_err", 32'(cap_err), 32'd0);
        cycle(0, 0, 0, 0, 1, 32'h0, 0);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t5_late_err", 32'(cap_err), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h0, 1);

        // Simultaneous push and pop at count 2: response goes to the older owner.
        cycle(1, 0, 0, 1, 0, 32'h0, 0);
        cycle(0, 1, 0, 1, 0, 32'h0, 0);
        cycle(1, 0, 0, 1, 1, 32'h6666_0000, 0);
        check("t6_idok",   32'(cap_idok), 32'd1);
        check("t6_ddok",   32'(cap_ddok), 32'd0);
        check("t6_push",   32'(cap_iaok), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);
        check("t6_cnt2",   32'(cap_cnt), 32'd2);
        cycle(0, 0, 0, 0, 1, 32'h6666_0001, 0);
        check("t6_d_next", 32'(cap_ddok), 32'd1);
        cycle(0, 0, 0, 0, 1, 32'h6666_0002, 0);
        check("t6_i_last", 32'(cap_idok), 32'd1);
        cycle(0, 0, 0, 0, 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
